// File: rtl/id_ex_control_stage.sv
// ID-stage opcode decoder and registered ID/EX control bundle.
// Handles load-use bubbles, downstream stall, branch flush and illegal-opcode accounting.
module id_ex_control_stage #(
    parameter int OP_W    = 6,
    parameter int ALUOP_W = 3,
    parameter int REG_W   = 5,
    parameter int CNT_W   = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               id_valid,
    input  logic [OP_W-1:0]    id_op,
    input  logic [REG_W-1:0]   id_rs,
    input  logic [REG_W-1:0]   id_rt,
    input  logic               stall_in,
    input  logic               flush,
    output logic               id_ready,
    output logic               ex_valid,
    output logic               ex_reg_dst,
    output logic               ex_branch,
    output logic               ex_bne,
    output logic               ex_mem_read,
    output logic               ex_mem_to_reg,
    output logic               ex_mem_write,
    output logic               ex_alu_src,
    output logic               ex_reg_write,
    output logic               ex_zero_ext,
    output logic               ex_jal,
    output logic               ex_rtype,
    output logic [ALUOP_W-1:0] ex_alu_op,
    output logic [REG_W-1:0]   ex_rt,
    output logic               illegal_err,
    output logic [CNT_W-1:0]   illegal_cnt
);

    typedef struct packed {
        logic               reg_dst;
        logic               branch;
        logic               bne;
        logic               mem_read;
        logic               mem_to_reg;
        logic               mem_write;
        logic               alu_src;
        logic               reg_write;
        logic               zero_ext;
        logic               jal;
        logic               rtype;
        logic [ALUOP_W-1:0] alu_op;
    } ctrl_t;

    localparam logic [ALUOP_W-1:0] ALU_ADD = ALUOP_W'(3'b000);
    localparam logic [ALUOP_W-1:0] ALU_SUB = ALUOP_W'(3'b001);
    localparam logic [ALUOP_W-1:0] ALU_FN  = ALUOP_W'(3'b010);
    localparam logic [ALUOP_W-1:0] ALU_OR  = ALUOP_W'(3'b011);
    localparam logic [ALUOP_W-1:0] ALU_AND = ALUOP_W'(3'b100);
    localparam logic [CNT_W-1:0]   CNT_MAX = '1;

    ctrl_t            dec;
    ctrl_t            ctrl_q;
    logic             illegal;
    logic             load_use;
    logic             accept;
    logic [OP_W-1:0]  op_hi;
    logic [5:0]       op6;

    // Opcodes are 6-bit codes; any set bit above [5:0] makes them illegal.
    assign op_hi = id_op >> 6;
    assign op6   = id_op[5:0];

    always_comb begin
        dec     = '0;
        illegal = 1'b0;
        if (op_hi != '0) begin
            dec.alu_op = ALU_SUB;
            illegal    = 1'b1;
        end else begin
            unique case (op6)
                6'b000000: begin
                    dec.reg_dst   = 1'b1;
                    dec.alu_op    = ALU_FN;
                    dec.reg_write = 1'b1;
                    dec.rtype     = 1'b1;
                end
                6'b100011: begin
                    dec.alu_src    = 1'b1;
                    dec.mem_to_reg = 1'b1;
                    dec.reg_write  = 1'b1;
                    dec.mem_read   = 1'b1;
                end
                6'b101011: begin
                    dec.alu_src   = 1'b1;
                    dec.mem_write = 1'b1;
                end
                6'b000100: begin
                    dec.branch = 1'b1;
                    dec.alu_op = ALU_SUB;
                end
                6'b000101: begin
                    dec.bne    = 1'b1;
                    dec.alu_op = ALU_SUB;
                end
                6'b001100: begin
                    dec.alu_src   = 1'b1;
                    dec.alu_op    = ALU_AND;
                    dec.reg_write = 1'b1;
                    dec.zero_ext  = 1'b1;
                end
                6'b001000: begin
                    dec.alu_src   = 1'b1;
                    dec.alu_op    = ALU_ADD;
                    dec.reg_write = 1'b1;
                end
                6'b001101: begin
                    dec.alu_src   = 1'b1;
                    dec.alu_op    = ALU_OR;
                    dec.reg_write = 1'b1;
                    dec.zero_ext  = 1'b1;
                end
                6'b000011: begin
                    dec.jal       = 1'b1;
                    dec.reg_write = 1'b1;
                end
                default: begin
                    dec.alu_op = ALU_SUB;
                    illegal    = 1'b1;
                end
            endcase
        end
    end

    assign load_use = ex_valid & ctrl_q.mem_read & id_valid
                    & (ex_rt != '0)
                    & ((ex_rt == id_rs) | (ex_rt == id_rt));

    assign id_ready = ~stall_in & ~load_use;
    assign accept   = ~flush & ~stall_in & ~load_use & id_valid & illegal;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid <= 1'b0;
            ctrl_q   <= '0;
            ex_rt    <= '0;
        end else if (flush) begin
            ex_valid <= 1'b0;
            ctrl_q   <= '0;
            ex_rt    <= '0;
        end else if (stall_in) begin
            ex_valid <= ex_valid;
            ctrl_q   <= ctrl_q;
            ex_rt    <= ex_rt;
        end else if (load_use) begin
            ex_valid <= 1'b0;
            ctrl_q   <= '0;
            ex_rt    <= '0;
        end else begin
            ex_valid <= id_valid;
            ctrl_q   <= id_valid ? dec : '0;
            ex_rt    <= id_valid ? id_rt : '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal_err <= 1'b0;
            illegal_cnt <= '0;
        end else if (accept) begin
            illegal_err <= 1'b1;
            if (illegal_cnt != CNT_MAX)
                illegal_cnt <= illegal_cnt + 1'b1;
        end
    end

    assign ex_reg_dst    = ctrl_q.reg_dst;
    assign ex_branch     = ctrl_q.branch;
    assign ex_bne        = ctrl_q.bne;
    assign ex_mem_read   = ctrl_q.mem_read;
    assign ex_mem_to_reg = ctrl_q.mem_to_reg;
    assign ex_mem_write  = ctrl_q.mem_write;
    assign ex_alu_src    = ctrl_q.alu_src;
    assign ex_reg_write  = ctrl_q.reg_write;
    assign ex_zero_ext   = ctrl_q.zero_ext;
    assign ex_jal        = ctrl_q.jal;
    assign ex_rtype      = ctrl_q.rtype;
    assign ex_alu_op     = ctrl_q.alu_op;

endmodule
